// File: rtl/ode_io_pkg.sv
// ============================================================================
// Module   : ode_io_pkg
// Summary  : Shared types and helpers for the ODE IO buffers.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ode_io_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } ram_state_e;

    // Widest word any IO buffer may merge; callers zero-extend and truncate.
    localparam int MERGE_MAX_W = 512;
    localparam int MERGE_MAX_B = MERGE_MAX_W / 8;

    function automatic logic [MERGE_MAX_W-1:0] byte_merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_B-1:0] mask
    );
        logic [MERGE_MAX_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < MERGE_MAX_B; b++) begin
            if (mask[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ram_clear_seq.sv
// ============================================================================
// Module   : ram_clear_seq
// Summary  : CLEAR/READY sequencer sweeping one word per cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_clear_seq
    import ode_io_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Init_Req,
    output logic             Ready,
    output logic             clr_en,
    output logic [PTR_W-1:0] clr_addr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    ram_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            CLEAR: begin
                // Park the pointer at 0 on exit so it never wraps past the end.
                if (ptr_q == LAST_PTR) begin
                    state_d = READY;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            READY: begin
                if (Init_Req) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                end
            end
            default: begin
                state_d = CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    assign Ready    = (state_q == READY);
    assign clr_en   = (state_q == CLEAR);
    assign clr_addr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/multiport_ram.sv
// ============================================================================
// Module   : multiport_ram
// Summary  : N-read / 1-write RAM with byte-masked write-first bypass,
//            clear sweep and sticky out-of-range error.
// Revision : 1.0
// ============================================================================
`default_nettype none

module multiport_ram
    import ode_io_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 13,
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 16,
    parameter int NUM_RD        = 2
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic                            Init_Req,
    output logic                            Ready,
    input  logic                            WR_Enable,
    input  logic [DATA_WIDTH/8-1:0]         WR_Mask,
    input  logic [ADDRESS_WIDTH-1:0]        address_WR,
    input  logic [DATA_WIDTH-1:0]           dataIn,
    input  logic [NUM_RD-1:0]               RD_Enable,
    input  logic [NUM_RD*ADDRESS_WIDTH-1:0] address_RD,
    output logic [NUM_RD*DATA_WIDTH-1:0]    dataOut,
    output logic [NUM_RD-1:0]               dataOut_Valid,
    output logic                            Addr_Err
);

    localparam int                     PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LIM = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic             clr_en;
    logic [PTR_W-1:0] clr_addr;

    ram_clear_seq #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_clear_seq (
        .CLK      (CLK),
        .RST      (RST),
        .Init_Req (Init_Req),
        .Ready    (Ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    logic                  wr_in_range, wr_ok, clr_we;
    logic [PTR_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_merged;
    logic [NUM_RD-1:0]     rd_oor;
    logic                  err_q, err_d;

    assign wr_in_range = ({1'b0, address_WR} < DEPTH_LIM);
    assign wr_idx      = address_WR[PTR_W-1:0];
    // RST gating keeps the array untouched while reset is held.
    assign wr_ok       = RST && Ready && WR_Enable && wr_in_range;
    assign clr_we      = RST && clr_en;
    assign wr_merged   = DATA_WIDTH'(byte_merge(MERGE_MAX_W'(mem_q[wr_idx]),
                                                MERGE_MAX_W'(dataIn),
                                                MERGE_MAX_B'(WR_Mask)));

    always_ff @(posedge CLK) begin
        if (clr_we) begin
            mem_q[clr_addr] <= '0;
        end else if (wr_ok) begin
            mem_q[wr_idx] <= wr_merged;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] rd_addr;
        logic                     rd_in_range;
        logic [DATA_WIDTH-1:0]    rd_data_q, rd_data_d;
        logic                     rd_valid_q, rd_valid_d;

        assign rd_addr     = address_RD[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
        assign rd_in_range = ({1'b0, rd_addr} < DEPTH_LIM);
        assign rd_oor[p]   = RD_Enable[p] && !rd_in_range;

        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
            if (Ready && RD_Enable[p]) begin
                rd_valid_d = 1'b1;
                if (!rd_in_range) begin
                    rd_data_d = '0;
                end else if (wr_ok && (rd_addr == address_WR)) begin
                    rd_data_d = wr_merged;
                end else begin
                    rd_data_d = mem_q[rd_addr[PTR_W-1:0]];
                end
            end
        end

        always_ff @(posedge CLK) begin
            if (!RST) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        assign dataOut[p*DATA_WIDTH +: DATA_WIDTH] = rd_data_q;
        assign dataOut_Valid[p]                    = rd_valid_q;
    end

    assign err_d = err_q | (Ready && ((WR_Enable && !wr_in_range) || (|rd_oor)));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Addr_Err = err_q;

endmodule

`default_nettype wire
